// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one CPU load/store at a time, answers after
// a fixed LATENCY of clock edges with a one-cycle ready pulse, and flags
// misaligned or out-of-range requests without touching memory.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no request in flight; a req at the next edge is accepted
//   BUSY  | request captured, latency counter running down
//   RESP  | last cycle before the response edge; a req here is accepted
//         | back-to-back at the same edge that raises ready
module data_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic accept;

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_wr;

    logic                 fault;
    logic [ADDR_BITS-1:0] word_idx;

    logic [31:0] mem [2**ADDR_BITS];

    // Misaligned low bits or any address bit above the array makes the
    // captured request a fault; the word index is the aligned word address.
    assign fault    = (cap_addr[1:0] != 2'b00) ||
                      ((cap_addr >> (ADDR_BITS + 2)) != 32'd0);
    assign word_idx = cap_addr[ADDR_BITS+1:2];

    // State and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; acceptance is only possible from IDLE or RESP.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req) accept = 1'b1;
            end
            BUSY: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
                if (req) accept = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (accept) begin
            cnt_nxt   = CNT_LOAD;
            state_nxt = (LATENCY == 1) ? RESP : BUSY;
        end
    end

    // Request capture and response registers; rdata/err hold between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_wr    <= 1'b0;
            ready     <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
        end else begin
            ready <= (state == RESP);
            if (state == RESP) begin
                err   <= fault;
                rdata <= (fault || cap_wr) ? 32'd0 : mem[word_idx];
            end
            if (accept) begin
                cap_addr  <= addr;
                cap_wdata <= wdata;
                cap_wr    <= wr_en;
            end
        end
    end

    // Store commit on the response edge; the array is never reset so its
    // contents survive rst, and an aborted request never reaches RESP.
    always_ff @(posedge clk) begin
        if ((state == RESP) && cap_wr && !fault) begin
            mem[word_idx] <= cap_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one LATENCY=2 instance and one LATENCY=1 instance,
// expected values written by hand into each step.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;

    logic        req2, wr2;
    logic [31:0] addr2, wdata2;
    logic        ready2, err2;
    logic [31:0] rdata2;

    logic        req1, wr1;
    logic [31:0] addr1, wdata1;
    logic        ready1, err1;
    logic [31:0] rdata1;

    int n_cmp = 0;
    int n_err = 0;

    data_mem_responder #(.ADDR_BITS(8), .LATENCY(2)) u_l2 (
        .clk   (clk),
        .rst   (rst),
        .req   (req2),
        .wr_en (wr2),
        .addr  (addr2),
        .wdata (wdata2),
        .ready (ready2),
        .rdata (rdata2),
        .err   (err2)
    );

    data_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_l1 (
        .clk   (clk),
        .rst   (rst),
        .req   (req1),
        .wr_en (wr1),
        .addr  (addr1),
        .wdata (wdata1),
        .ready (ready1),
        .rdata (rdata1),
        .err   (err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated LATENCY=2 transaction; inputs are scrambled after acceptance.
    task automatic txn2(input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd);
        req2 = 1'b1; wr2 = wr; addr2 = a; wdata2 = d;
        tick();
        req2 = 1'b0; wr2 = ~wr; addr2 = ~a; wdata2 = ~d;
        chk({tag, "_rdy_n0"}, 32'(ready2), 32'd0);
        tick();
        chk({tag, "_rdy_n1"}, 32'(ready2), 32'd0);
        tick();
        chk({tag, "_rdy"},   32'(ready2), 32'd1);
        chk({tag, "_err"},   32'(err2),   32'(exp_err));
        chk({tag, "_rdata"}, rdata2,      exp_rd);
        tick();
        chk({tag, "_rdy_off"},    32'(ready2), 32'd0);
        chk({tag, "_rdata_hold"}, rdata2,      exp_rd);
        chk({tag, "_err_hold"},   32'(err2),   32'(exp_err));
    endtask

    initial begin
        rst = 1'b1;
        req2 = 1'b0; wr2 = 1'b0; addr2 = 32'd0; wdata2 = 32'd0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        #1;
        chk("rst_ready", 32'(ready2), 32'd0);
        chk("rst_err",   32'(err2),   32'd0);
        chk("rst_rdata", rdata2,      32'd0);
        chk("rst_ready_l1", 32'(ready1), 32'd0);

        tick();                 // edge 1
        tick();                 // edge 2
        rst = 1'b0;
        tick();                 // edge 3
        tick();                 // edge 4
        chk("idle_ready", 32'(ready2), 32'd0);

        // Store accepted at edge 5, ready during cycle 7, then load it back.
        txn2("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0);
        txn2("ld10", 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEAD_BEEF);

        // Faults: misaligned load, out-of-range store aliasing word 0.
        txn2("st00",  1'b1, 32'h0,   32'h1111_2222, 1'b0, 32'd0);
        txn2("ld13",  1'b0, 32'h13,  32'h0,         1'b1, 32'd0);
        txn2("st400", 1'b1, 32'h400, 32'h0000_0BAD, 1'b1, 32'd0);
        txn2("ld00",  1'b0, 32'h0,   32'h0,         1'b0, 32'h1111_2222);

        // Preload 0x40..0x5C with 0x1000+i.
        for (int i = 0; i < 8; i++) begin
            txn2("pre", 1'b1, 32'h40 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 32'd0);
        end

        // req held for 8 cycles with a new addr every cycle: only 0x40, 0x48,
        // 0x50, 0x58 get accepted; BUSY-cycle addresses are dropped.
        for (int i = 0; i < 8; i++) begin
            req2 = 1'b1; wr2 = 1'b0; addr2 = 32'h40 + 32'(4 * i);
            tick();
            if (i >= 2 && (i % 2) == 0) begin
                chk("stream_rdy",   32'(ready2), 32'd1);
                chk("stream_rdata", rdata2,      32'h1000 + 32'(i - 2));
                chk("stream_err",   32'(err2),   32'd0);
            end else begin
                chk("stream_rdy_gap", 32'(ready2), 32'd0);
            end
        end
        req2 = 1'b0;
        tick();
        chk("stream_last_rdy",   32'(ready2), 32'd1);
        chk("stream_last_rdata", rdata2,      32'h1006);
        tick();
        chk("stream_end_rdy", 32'(ready2), 32'd0);
        tick();
        chk("stream_no_extra", 32'(ready2), 32'd0);

        // Reset in BUSY aborts a store; rdata/err drop without a clock edge.
        txn2("st20", 1'b1, 32'h20, 32'hCAFE_0020, 1'b0, 32'd0);
        txn2("ld20", 1'b0, 32'h20, 32'h0,         1'b0, 32'hCAFE_0020);
        req2 = 1'b1; wr2 = 1'b1; addr2 = 32'h20; wdata2 = 32'h1234_5678;
        tick();
        req2 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(ready2), 32'd0);
        chk("arst_rdata", rdata2,      32'd0);
        chk("arst_err",   32'(err2),   32'd0);
        tick();
        chk("arst_hold_rdy", 32'(ready2), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_rdy0", 32'(ready2), 32'd0);
        tick();
        chk("post_rst_rdy1", 32'(ready2), 32'd0);
        txn2("ld20_kept", 1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFE_0020);

        // LATENCY=1 back-to-back store then load of 0x8.
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h8; wdata1 = 32'hA5A5_A5A5;
        tick();
        wr1 = 1'b0; wdata1 = 32'h0;
        chk("l1_acc_rdy", 32'(ready1), 32'd0);
        tick();
        req1 = 1'b0; addr1 = 32'hFC;
        chk("l1_st_rdy",   32'(ready1), 32'd1);
        chk("l1_st_err",   32'(err1),   32'd0);
        chk("l1_st_rdata", rdata1,      32'd0);
        tick();
        chk("l1_ld_rdy",   32'(ready1), 32'd1);
        chk("l1_ld_rdata", rdata1,      32'hA5A5_A5A5);
        chk("l1_ld_err",   32'(err1),   32'd0);
        tick();
        chk("l1_end_rdy",   32'(ready1), 32'd0);
        chk("l1_end_rdata", rdata1,      32'hA5A5_A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
